// File: rtl/cpu_controller.sv
// Instruction sequencer for the register-file/ALU datapath: one instruction per s strobe.
// Outputs are registered from the next state, so each strobe is glitch-free for its whole state.
module cpu_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [3:0] vsel,
    output logic       write,
    output logic       illegal
);

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        ALU       = 3'd5,
        WRITE_REG = 3'd6
    } state_t;

    state_t     state, nxt;
    logic [4:0] instr;
    logic       legal, is_cmp, asel_alu;

    assign instr    = {opcode, op};
    assign is_cmp   = (instr == 5'b101_01);
    // MOV reg and MVN pass B straight through, so A is forced to zero
    assign asel_alu = (opcode == 3'b110) || (instr == 5'b101_11);

    always_comb begin
        legal = 1'b0;
        case (instr)
            5'b110_10, 5'b110_00, 5'b101_11,
            5'b101_00, 5'b101_01, 5'b101_10: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt = WAIT;
        case (state)
            WAIT:      nxt = s ? DECODE : WAIT;
            DECODE: begin
                case (instr)
                    5'b110_10:                       nxt = WRITE_IMM;
                    5'b110_00, 5'b101_11:            nxt = GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: nxt = GET_A;
                    default:                         nxt = WAIT;
                endcase
            end
            WRITE_IMM: nxt = WAIT;
            GET_A:     nxt = GET_B;
            GET_B:     nxt = ALU;
            ALU:       nxt = is_cmp ? WAIT : WRITE_REG;
            WRITE_REG: nxt = WAIT;
            default:   nxt = WAIT;
        endcase
    end

    // illegal for DECODE is computed as s is sampled, so the instruction must be valid then
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= WAIT;
            w       <= 1'b1;
            nsel    <= 3'b000;
            loada   <= 1'b0;
            loadb   <= 1'b0;
            asel    <= 1'b0;
            bsel    <= 1'b0;
            loadc   <= 1'b0;
            loads   <= 1'b0;
            vsel    <= 4'b0000;
            write   <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= nxt;
            w       <= (nxt == WAIT);
            nsel    <= (nxt == WRITE_IMM || nxt == GET_A) ? 3'b100 :
                       (nxt == GET_B)                     ? 3'b001 :
                       (nxt == WRITE_REG)                 ? 3'b010 : 3'b000;
            loada   <= (nxt == GET_A);
            loadb   <= (nxt == GET_B);
            asel    <= (nxt == ALU) && asel_alu;
            bsel    <= 1'b0;
            loadc   <= (nxt == ALU) && !is_cmp;
            loads   <= (nxt == ALU) && is_cmp;
            vsel    <= (nxt == WRITE_IMM) ? 4'b0100 :
                       (nxt == WRITE_REG) ? 4'b0001 : 4'b0000;
            write   <= (nxt == WRITE_IMM) || (nxt == WRITE_REG);
            illegal <= (nxt == DECODE) && !legal;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: vector table, hand-built corner sequences and a
// randomized run checked against an instruction-level trace model.
module tb_cpu_controller;

    logic       clk, reset, s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, loada, loadb, asel, bsel, loadc, loads, write, illegal;
    logic [2:0] nsel;
    logic [3:0] vsel;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_controller dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .asel(asel),
        .bsel(bsel), .loadc(loadc), .loads(loads), .vsel(vsel),
        .write(write), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] dv;
    assign dv = {w, nsel, loada, loadb, asel, bsel, loadc, loads, vsel, write, illegal};

    function automatic logic [15:0] mk(input logic ww, input logic [2:0] ns,
                                       input logic la, input logic lb, input logic as,
                                       input logic lc, input logic ls, input logic [3:0] vs,
                                       input logic wr, input logic il);
        return {ww, ns, la, lb, as, 1'b0, lc, ls, vs, wr, il};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-edge output trace for one instruction, from the instruction class
    logic [15:0] exp_q[$];

    task automatic model(input logic [2:0] opc, input logic [1:0] o);
        logic mov_imm, mov_reg, mvn, cmp, arith, legal;
        mov_imm = (opc == 3'b110) && (o == 2'b10);
        mov_reg = (opc == 3'b110) && (o == 2'b00);
        mvn     = (opc == 3'b101) && (o == 2'b11);
        cmp     = (opc == 3'b101) && (o == 2'b01);
        arith   = (opc == 3'b101) && (o != 2'b11);
        legal   = mov_imm || mov_reg || mvn || arith;
        exp_q.delete();
        exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 4'b0000, 0, !legal));
        if (mov_imm)
            exp_q.push_back(mk(0, 3'b100, 0, 0, 0, 0, 0, 4'b0100, 1, 0));
        else if (legal) begin
            if (arith) exp_q.push_back(mk(0, 3'b100, 1, 0, 0, 0, 0, 4'b0000, 0, 0));
            exp_q.push_back(mk(0, 3'b001, 0, 1, 0, 0, 0, 4'b0000, 0, 0));
            exp_q.push_back(mk(0, 3'b000, 0, 0, mov_reg || mvn, !cmp, cmp, 4'b0000, 0, 0));
            if (!cmp) exp_q.push_back(mk(0, 3'b010, 0, 0, 0, 0, 0, 4'b0001, 1, 0));
        end
        exp_q.push_back(mk(1, 3'b000, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    endtask

    typedef struct {
        logic [2:0] opc;
        logic [1:0] o;
        int lat, n_la, n_lb, n_lc, n_ls, n_wr, n_il, n_as;
    } vec_t;

    vec_t vt[10];

    task automatic run_vec(input vec_t v);
        int edges = 0, la = 0, lb = 0, lc = 0, ls = 0, wr = 0, il = 0, as = 0, viol = 0;
        opcode = v.opc; op = v.o; s = 1'b1;
        do begin
            step();
            s = 1'b0;
            edges++;
            la += loada; lb += loadb; lc += loadc; ls += loads;
            wr += write; il += illegal; as += asel;
            if ((loada + loadb + loadc + loads + write) > 1) viol++;
            if (nsel != 3'b000 && !(loada || loadb || write)) viol++;
            if (bsel) viol++;
        end while (!w && edges < 20);
        chk($sformatf("lat_%b_%b", v.opc, v.o), edges, v.lat);
        chk("n_loada", la, v.n_la);
        chk("n_loadb", lb, v.n_lb);
        chk("n_loadc", lc, v.n_lc);
        chk("n_loads", ls, v.n_ls);
        chk("n_write", wr, v.n_wr);
        chk("n_illegal", il, v.n_il);
        chk("n_asel", as, v.n_as);
        chk("strobe_rules", viol, 0);
    endtask

    task automatic run_model(input logic [2:0] opc, input logic [1:0] o);
        model(opc, o);
        opcode = opc; op = o; s = 1'b1;
        foreach (exp_q[i]) begin
            step();
            s = 1'b0;
            chk($sformatf("trace_%b_%b_e%0d", opc, o, i + 1), dv, exp_q[i]);
        end
    endtask

    localparam logic [4:0] LEGAL_LIST [6] = '{5'b110_10, 5'b110_00, 5'b101_11,
                                              5'b101_00, 5'b101_01, 5'b101_10};

    initial begin
        logic [15:0] v_wait;
        int nw, nwr, consec;
        logic prev_w;
        logic [4:0] pick;

        v_wait = mk(1, 3'b000, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        vt[0] = '{3'b110, 2'b10, 3, 0, 0, 0, 0, 1, 0, 0};
        vt[1] = '{3'b110, 2'b00, 5, 0, 1, 1, 0, 1, 0, 1};
        vt[2] = '{3'b101, 2'b11, 5, 0, 1, 1, 0, 1, 0, 1};
        vt[3] = '{3'b101, 2'b00, 6, 1, 1, 1, 0, 1, 0, 0};
        vt[4] = '{3'b101, 2'b01, 5, 1, 1, 0, 1, 0, 0, 0};
        vt[5] = '{3'b101, 2'b10, 6, 1, 1, 1, 0, 1, 0, 0};
        vt[6] = '{3'b111, 2'b00, 2, 0, 0, 0, 0, 0, 1, 0};
        vt[7] = '{3'b110, 2'b01, 2, 0, 0, 0, 0, 0, 1, 0};
        vt[8] = '{3'b000, 2'b00, 2, 0, 0, 0, 0, 0, 1, 0};
        vt[9] = '{3'b110, 2'b11, 2, 0, 0, 0, 0, 0, 1, 0};

        reset = 1'b0; s = 1'b0; opcode = 3'b000; op = 2'b00;
        #1 reset = 1'b1;
        #1 chk("reset_state", dv, v_wait);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
        chk("idle_after_reset", dv, v_wait);

        foreach (vt[i]) run_vec(vt[i]);

        // Reset during GET_B of an ADD must take effect without a clock edge
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        step(); s = 1'b0;
        step();
        step();
        chk("add_in_get_b", loadb, 1'b1);
        #2 reset = 1'b1;
        #1 chk("async_reset_w", w, 1'b1);
        chk("async_reset_loadb", loadb, 1'b0);
        chk("async_reset_vec", dv, v_wait);
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_reset_idle", dv, v_wait);
        end

        // s held high: WAIT lasts one cycle between back-to-back MOV imm
        opcode = 3'b110; op = 2'b10; s = 1'b1;
        nw = 0; nwr = 0; consec = 0; prev_w = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            nw += w; nwr += write;
            if (w && prev_w) consec++;
            prev_w = w;
        end
        s = 1'b0;
        chk("b2b_wait_cycles", nw, 3);
        chk("b2b_writes", nwr, 3);
        chk("b2b_no_double_wait", consec, 0);
        begin
            int k = 0;
            while (!w && k < 10) begin step(); k++; end
            chk("b2b_drain", w, 1'b1);
        end

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 7) pick = LEGAL_LIST[$urandom_range(0, 5)];
            else pick = 5'($urandom);
            run_model(pick[4:2], pick[1:0]);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                opcode = 3'($urandom); op = 2'($urandom);
                step();
                chk("rand_idle", dv, v_wait);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
